param_core_distributor: RTL and testbench

- Generalised parameter-load distributor for an N-core RANC grid, running in the grid clock domain behind the CDC parameter FIFO read side.
- Steers a serial stream of parameter words into per-core write ports and generates per-core addresses.
- Advances between cores automatically or under host selection, excluding the output-bus tile.
- Returns a one-cycle next-core request toward the host-side sync.

---
 rtl/param_core_distributor.sv | 142 ++++++++++++++
 tb/tb_param_core_distributor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_core_distributor.sv
// rtl/param_core_distributor.sv - steers a serial parameter-word stream into per-core write ports
// Loads cores sequentially (auto) or one at a time (manual), never touching SKIP_CORE.
module param_core_distributor #(
   parameter int NUM_CORES      = 6,
   parameter int DATA_W         = 32,
   parameter int WORDS_PER_CORE = 256,
   parameter int IDLE_CYCLES    = 2,
   parameter int SKIP_CORE      = 5,
   parameter int CORE_W         = $clog2(NUM_CORES),
   parameter int ADDR_W         = $clog2(WORDS_PER_CORE)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 auto_mode,
   input  logic [CORE_W-1:0]    sel_core,
   input  logic                 in_valid,
   input  logic [DATA_W-1:0]    in_data,
   output logic                 in_ready,
   output logic [NUM_CORES-1:0] core_wen,
   output logic [DATA_W-1:0]    core_wdata,
   output logic [ADDR_W-1:0]    core_waddr,
   output logic [CORE_W-1:0]    cur_core,
   output logic [NUM_CORES-1:0] core_done,
   output logic                 next_core_req,
   output logic                 all_done,
   output logic                 err
);

   localparam int GAP_W = $clog2(IDLE_CYCLES + 1);
   localparam logic [ADDR_W-1:0]    LAST_ADDR  = ADDR_W'(WORDS_PER_CORE - 1);
   localparam logic [CORE_W-1:0]    FIRST_CORE = (SKIP_CORE == 0) ? CORE_W'(1) : '0;
   // Shifting past the top bit leaves every core loadable when skipping is disabled.
   localparam logic [NUM_CORES-1:0] LOAD_MASK  = ~(NUM_CORES'(1) << SKIP_CORE);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GAP, S_DONE} state_t;

   state_t            state;
   logic              mode_auto;
   logic [ADDR_W-1:0] word_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [CORE_W:0]   step_core;
   logic [CORE_W:0]   next_core;
   logic              last_core;
   logic              sel_bad;

   assign in_ready = (state == S_LOAD);

   always_comb begin
      step_core = {1'b0, cur_core} + (CORE_W + 1)'(1);
      next_core = (int'(step_core) == SKIP_CORE) ? step_core + (CORE_W + 1)'(1) : step_core;
   end

   assign last_core = (int'(next_core) >= NUM_CORES);
   assign sel_bad   = (int'(sel_core) >= NUM_CORES) || (int'(sel_core) == SKIP_CORE) ||
                      (|(core_done & (NUM_CORES'(1) << sel_core)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         mode_auto     <= 1'b0;
         word_cnt      <= '0;
         gap_cnt       <= '0;
         core_wen      <= '0;
         core_wdata    <= '0;
         core_waddr    <= '0;
         cur_core      <= '0;
         core_done     <= '0;
         next_core_req <= 1'b0;
         all_done      <= 1'b0;
         err           <= 1'b0;
      end else begin
         core_wen      <= '0;
         next_core_req <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (state == S_DONE && in_valid) err <= 1'b1;
               if (start) begin
                  if (auto_mode) begin
                     core_done <= '0;
                     all_done  <= 1'b0;
                     err       <= 1'b0;
                     mode_auto <= 1'b1;
                     cur_core  <= FIRST_CORE;
                     word_cnt  <= '0;
                     state     <= S_LOAD;
                  end else if (sel_bad) begin
                     err <= 1'b1;
                  end else begin
                     err       <= 1'b0;
                     mode_auto <= 1'b0;
                     cur_core  <= sel_core;
                     word_cnt  <= '0;
                     state     <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  core_wen   <= NUM_CORES'(1) << cur_core;
                  core_wdata <= in_data;
                  core_waddr <= word_cnt;
                  if (word_cnt == LAST_ADDR) begin
                     core_done     <= core_done | (NUM_CORES'(1) << cur_core);
                     word_cnt      <= '0;
                     gap_cnt       <= '0;
                     next_core_req <= (IDLE_CYCLES == 1);
                     state         <= S_GAP;
                  end else begin
                     word_cnt <= word_cnt + ADDR_W'(1);
                  end
               end
            end
            S_GAP: begin
               if (int'(gap_cnt) == IDLE_CYCLES - 1) begin
                  gap_cnt <= '0;
                  if (mode_auto) begin
                     if (last_core) begin
                        all_done <= 1'b1;
                        state    <= S_DONE;
                     end else begin
                        cur_core <= next_core[CORE_W-1:0];
                        state    <= S_LOAD;
                     end
                  end else if ((core_done & LOAD_MASK) == LOAD_MASK) begin
                     all_done <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
                  // Registered pulse lands on the final gap cycle.
                  next_core_req <= (int'(gap_cnt) + 2 == IDLE_CYCLES);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_param_core_distributor.sv
// tb/tb_param_core_distributor.sv - scoreboard bench for param_core_distributor
// Driver pushes expected writes/pulses from a core-plan model; a negedge monitor pops and compares.
module tb_param_core_distributor;

   localparam int NC    = 6;
   localparam int DW    = 32;
   localparam int WPC   = 4;
   localparam int IDLEC = 2;
   localparam int SKIP  = 5;
   localparam int CW    = $clog2(NC);
   localparam int AW    = $clog2(WPC);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          auto_mode = 1'b0;
   logic [CW-1:0] sel_core = '0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic [NC-1:0] core_wen;
   logic [DW-1:0] core_wdata;
   logic [AW-1:0] core_waddr;
   logic [CW-1:0] cur_core;
   logic [NC-1:0] core_done;
   logic          next_core_req;
   logic          all_done;
   logic          err;

   param_core_distributor #(
      .NUM_CORES(NC), .DATA_W(DW), .WORDS_PER_CORE(WPC), .IDLE_CYCLES(IDLEC), .SKIP_CORE(SKIP)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .auto_mode(auto_mode), .sel_core(sel_core),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .core_wen(core_wen),
      .core_wdata(core_wdata), .core_waddr(core_waddr), .cur_core(cur_core), .core_done(core_done),
      .next_core_req(next_core_req), .all_done(all_done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          core;
      int          addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t           exp_q[$];
   int            req_q[$];
   int            plan_q[$];
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            n_pulse = 0;
   logic [NC-1:0] model_done = '0;
   logic [NC-1:0] load_mask;
   logic          model_all = 1'b0;
   logic          model_err = 1'b0;
   int            model_idx = 0;
   logic [31:0]   data_next = 32'h100;
   logic          seq_data = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string name);
      check(name, 64'({in_ready, core_wen, core_wdata, core_waddr, cur_core, core_done,
                       next_core_req, all_done, err}), 64'(0));
   endtask

   task automatic check_flags(input string name);
      check({name, "_done"}, 64'(core_done), 64'(model_done));
      check({name, "_all"}, 64'(all_done), 64'(model_all));
      check({name, "_err"}, 64'(err), 64'(model_err));
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (core_wen != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_wen", 64'(core_wen), 64'(0));
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wen", 64'(core_wen), 64'(NC'(1) << e.core));
               check("waddr", 64'(core_waddr), 64'(e.addr));
               check("wdata", 64'(core_wdata), 64'(e.data));
               check("wlatency", 64'(cyc), 64'(e.cyc));
            end
         end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            check("missing_wen", 64'(0), 64'(1));
            void'(exp_q.pop_front());
         end
         if (next_core_req) begin
            n_pulse++;
            if (req_q.size() == 0) check("unexpected_req", 64'(1), 64'(0));
            else check("req_cycle", 64'(cyc), 64'(req_q.pop_front()));
         end else if (req_q.size() > 0 && cyc > req_q[0]) begin
            check("missing_req", 64'(0), 64'(1));
            void'(req_q.pop_front());
         end
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      #2 check_zero("in_reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete(); req_q.delete(); plan_q.delete();
      model_done = '0; model_all = 1'b0; model_err = 1'b0; model_idx = 0;
   endtask

   task automatic do_start(input logic am, input int sel);
      @(negedge clk);
      start = 1'b1; auto_mode = am; sel_core = CW'(sel);
      if (am) begin
         model_done = '0; model_all = 1'b0; model_err = 1'b0; model_idx = 0;
         plan_q.delete();
         for (int i = 0; i < NC; i++) if (i != SKIP) plan_q.push_back(i);
      end else if (sel >= NC || sel == SKIP || model_done[sel]) begin
         model_err = 1'b1;
      end else begin
         model_err = 1'b0; model_idx = 0;
         plan_q.delete();
         plan_q.push_back(sel);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   // pattern 0: always valid; 1: valid 1,0,0,1 repeating; 2: random valid plus ignored starts
   task automatic feed(input int pattern, input int max_words);
      int   k = 0;
      int   t = 0;
      int   acc = 0;
      logic v;
      while (plan_q.size() > 0 && acc < max_words && t < 2000) begin
         @(negedge clk);
         t++;
         case (pattern)
            0:       v = 1'b1;
            1:       v = (k % 4 == 0) || (k % 4 == 3);
            default: v = 1'($urandom_range(0, 1));
         endcase
         k++;
         if (pattern == 2) begin
            start = ($urandom_range(0, 5) == 0);
            auto_mode = 1'($urandom_range(0, 1));
            sel_core = CW'($urandom_range(0, 7));
         end
         in_valid = v;
         in_data = data_next;
         if (v && in_ready) begin
            exp_q.push_back('{plan_q[0], model_idx, data_next, cyc + 1});
            data_next = seq_data ? data_next + 32'd1 : $urandom;
            acc++;
            model_idx++;
            if (model_idx == WPC) begin
               model_idx = 0;
               model_done[plan_q[0]] = 1'b1;
               req_q.push_back(cyc + 2);
               void'(plan_q.pop_front());
               if (plan_q.size() == 0) model_all = ((model_done & load_mask) == load_mask);
            end
         end
      end
      if (t >= 2000) check("feed_timeout", 64'(t), 64'(0));
      @(negedge clk);
      in_valid = 1'b0; start = 1'b0;
   endtask

   task automatic drain(input string name);
      repeat (IDLEC + 4) @(negedge clk);
      check({name, "_wq_empty"}, 64'(exp_q.size()), 64'(0));
      check({name, "_rq_empty"}, 64'(req_q.size()), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      load_mask = '0;
      for (int i = 0; i < NC; i++) if (i != SKIP) load_mask[i] = 1'b1;

      // 1: reset and idle
      apply_reset();
      repeat (10) @(negedge clk);
      check_zero("idle");

      // 2: auto load with sequential data
      seq_data = 1'b1; data_next = 32'h100;
      n_pulse = 0;
      do_start(1'b1, 0);
      feed(0, 1000);
      drain("auto_seq");
      check_flags("auto_seq");
      check("auto_seq_pulses", 64'(n_pulse), 64'(5));

      // 3: manual loads accumulating to all_done
      seq_data = 1'b0;
      apply_reset();
      do_start(1'b0, 3);
      feed(0, 1000);
      drain("man3");
      check_flags("man3");
      foreach (plan_q[i]) check("man3_plan", 64'(1), 64'(0));
      for (int c = 0; c < NC; c++) begin
         if (c == 3 || c == SKIP) continue;
         do_start(1'b0, c);
         feed(2, 1000);
         drain("man_more");
         check_flags("man_more");
      end

      // 4: rejected manual starts
      apply_reset();
      do_start(1'b0, 5);
      check_flags("sel5");
      do_start(1'b0, 0);
      check_flags("sel0_clear");
      feed(0, 1000);
      drain("sel0");
      do_start(1'b0, 7);
      check_flags("sel7");
      do_start(1'b0, 0);
      check_flags("sel0_again");
      do_start(1'b0, 1);
      check_flags("sel1_clear");
      feed(1, 1000);
      drain("sel1");
      check_flags("sel1");

      // 5: auto with gapped valid, then random valid restarted from DONE
      apply_reset();
      do_start(1'b1, 0);
      feed(1, 1000);
      drain("auto_gap");
      check_flags("auto_gap");
      do_start(1'b1, 0);
      check_flags("auto_rand_start");
      feed(2, 1000);
      drain("auto_rand");
      check_flags("auto_rand");

      // 6: overflow in DONE, then reset mid-load and restart
      @(negedge clk);
      in_valid = 1'b1;
      model_err = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_flags("overflow");
      do_start(1'b1, 0);
      check_flags("restart_clear");
      feed(0, 2);
      drain("partial");
      apply_reset();
      check_zero("after_abort");
      do_start(1'b1, 0);
      feed(2, 1000);
      drain("post_abort");
      check_flags("post_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
